// File: rtl/rom_loader.sv
// Streams a little-endian program image (word count header + payload words)
// into instruction memory, holding the core in reset until the load completes.
module rom_loader #(
  parameter int unsigned MEM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic        cpu_rst_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] checksum_o
);

  typedef enum logic [2:0] {IDLE, HDR, DATA, LAST, DONE, ERR} state_t;

  state_t      state_q, state_d;
  logic [1:0]  byte_cnt;
  logic [23:0] shift_q;
  logic [31:0] n_words;
  logic [31:0] word_idx;
  logic [31:0] assembled;
  logic        accept;
  logic        word_done;
  logic        restart;

  assign byte_ready_o = (state_q == HDR) || (state_q == DATA);
  assign accept       = byte_valid_i && byte_ready_o;
  assign word_done    = accept && (byte_cnt == 2'd3);
  // The byte arriving now becomes the top byte of the word being assembled.
  assign assembled    = {byte_i, shift_q};
  assign restart      = start_i &&
                        ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));

  assign cpu_rst_o = (state_q != DONE);
  assign done_o    = (state_q == DONE);
  assign err_o     = (state_q == ERR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERR: if (start_i) state_d = HDR;
      HDR: begin
        if (word_done)
          state_d = ((assembled == 32'd0) || (assembled > MEM_WORDS)) ? ERR : DATA;
      end
      DATA: begin
        if (word_done && (word_idx == n_words - 32'd1)) state_d = LAST;
      end
      LAST:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Byte assembly, the one-cycle write strobe and the running checksum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt   <= 2'd0;
      shift_q    <= 24'd0;
      n_words    <= 32'd0;
      word_idx   <= 32'd0;
      mem_we_o   <= 1'b0;
      mem_addr_o <= 32'd0;
      mem_data_o <= 32'd0;
      checksum_o <= 32'd0;
    end else begin
      mem_we_o <= 1'b0;
      if (restart) begin
        byte_cnt   <= 2'd0;
        word_idx   <= 32'd0;
        checksum_o <= 32'd0;
      end else if (mem_we_o) begin
        checksum_o <= checksum_o + mem_data_o;
      end
      if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        shift_q  <= assembled[31:8];
        if (byte_cnt == 2'd3) begin
          if (state_q == HDR) begin
            n_words  <= assembled;
            word_idx <= 32'd0;
          end else begin
            mem_we_o   <= 1'b1;
            mem_addr_o <= word_idx << 2;
            mem_data_o <= assembled;
            word_idx   <= word_idx + 32'd1;
          end
        end
      end
    end
  end

endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 The block SHALL have parameter MEM_WORDS, default 4096, meaning instruction memory capacity in 32-bit words.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-004 The block SHALL have port start_i, input, 1, a load request sampled each clock.
REQ-005 The block SHALL have port byte_i, input, 8, the incoming stream byte.
REQ-006 The block SHALL have port byte_valid_i, input, 1, asserted while byte_i holds a valid byte.
REQ-007 The block SHALL have port byte_ready_o, output, 1, asserted while the block can accept a byte.
REQ-008 The block SHALL have port mem_we_o, output, 1, the instruction-memory write strobe.
REQ-009 The block SHALL have port mem_addr_o, output, 32, the byte address of the write, in the same address space as the core's inst_addr.
REQ-010 The block SHALL have port mem_data_o, output, 32, the write data word.
REQ-011 The block SHALL have port cpu_rst_o, output, 1, holding the core in reset while high.
REQ-012 The block SHALL have port done_o, output, 1, the load-complete status.
REQ-013 The block SHALL have port err_o, output, 1, the bad-header status.
REQ-014 The block SHALL have port checksum_o, output, 32, the modulo-2^32 sum of all payload words written.

Function
REQ-015 The block SHALL implement states IDLE, HDR, DATA, LAST, DONE and ERR.
REQ-016 A byte SHALL be accepted on a rising edge where byte_valid_i and byte_ready_o are both high; byte_i and byte_valid_i are ignored at all other times.
REQ-017 byte_ready_o SHALL be high in HDR and DATA and low in IDLE, LAST, DONE and ERR.
REQ-018 Stream format: 4 header bytes form word count N, then 4*N payload bytes; all words are little-endian (first byte received is bits 7:0).
REQ-019 Transition IDLE->HDR: start_i high; this clears the byte counter, word index and checksum_o.
REQ-020 Transition DONE->HDR and ERR->HDR: start_i high; this also clears done_o and err_o.
REQ-021 start_i SHALL be ignored in HDR, DATA and LAST.
REQ-022 On acceptance of the 4th header byte, the next state SHALL be ERR if N==0 or N>MEM_WORDS, otherwise DATA with word index 0.
REQ-023 On acceptance of the 4th byte of payload word k, with k<N-1: mem_we_o SHALL be high for exactly the following cycle, with mem_addr_o=4*k and mem_data_o equal to the assembled word; the state SHALL remain DATA and byte_ready_o SHALL stay high, so back-to-back bytes are accepted without stall.
REQ-024 On acceptance of the 4th byte of word N-1, the state SHALL go to LAST, and mem_we_o, mem_addr_o and mem_data_o SHALL behave as in REQ-023 during the LAST cycle.
REQ-025 The state SHALL go from LAST to DONE unconditionally after one cycle.
REQ-026 checksum_o SHALL add each word in the same cycle its mem_we_o pulse is high; the updated value is visible from the next cycle.
REQ-027 cpu_rst_o SHALL be low only in DONE and high in every other state, so the core is released one cycle after the final write.
REQ-028 done_o SHALL be high only in DONE; err_o SHALL be high only in ERR.
REQ-029 mem_addr_o and mem_data_o SHALL hold their last value when mem_we_o is low; mem_we_o SHALL never be high for two consecutive cycles.
REQ-030 Gaps in byte_valid_i SHALL be tolerated at any byte position with no timeout.

Reset
REQ-031 While rst is high, the state SHALL be IDLE and the outputs SHALL be: byte_ready_o=0, mem_we_o=0, mem_addr_o=0, mem_data_o=0, cpu_rst_o=1, done_o=0, err_o=0, checksum_o=0.
REQ-032 Assertion of rst mid-load SHALL abort immediately with no further write pulse; a fresh start_i is required after release.

Verification
REQ-033 start; stream 02 00 00 00, 13 00 00 00, 6F 00 00 00 with valid held high -> writes (0x0,0x00000013) then (0x4,0x0000006F); DONE; checksum_o=0x00000082; cpu_rst_o falls one cycle after the second write.
REQ-034 The same stream with byte_valid_i toggling 1/0 every cycle -> identical writes, checksum and final state.
REQ-035 Header 00 00 00 00 -> ERR, err_o=1, no mem_we_o pulse, cpu_rst_o stays 1; then start_i -> HDR with err_o=0.
REQ-036 With MEM_WORDS=4, header 05 00 00 00 -> ERR; header 04 00 00 00 followed by 16 bytes -> last write at address 0xC, then DONE.
REQ-037 rst pulsed after 6 payload bytes -> all outputs return to their reset values, no further writes occur, and start_i plus a full stream then loads correctly.
REQ-038 start_i pulsed during DATA, and byte_valid_i held high in LAST or DONE -> ignored; no extra bytes consumed and no extra writes.
